icache_frontend: RTL and testbench
==================================

Name: icache_frontend

Overview:
- 3-wide instruction cache serving the fetch stage. It is the responder end of the fetch-to-icache interface.
- Combinationally returns up to three 32-bit instructions for three fetch PCs.
- Tracks one outstanding line miss to instruction memory over the tagged BUS_LOAD protocol.
- Direct-mapped, 8-byte lines (two instructions per line); fills on memory tag match.

Parameters:
- CACHE_LINES, 32, number of direct-mapped lines (power of 2); index = addr[3+IDX_W-1:3], tag = addr[XLEN-1:3+IDX_W].
- MEM_TAG_W, 4, width of memory transaction tag; tag 0 means "no response".

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- proc2Icache_addr  in  3x`XLEN  fetch PCs; slot 2 is oldest, slot 0 youngest.
- shift  in  2  fetch consumed-slot count; used only with ICACHE_PREFETCH_EN.
- hit_but_stall  in  1  fetch stalled on a line already hit; blocks new miss issue.
- take_branch  in  1  fetch redirect; abandons an un-issued miss.
- Icache_data_out  out  3x32  instruction per slot; 0 when the slot misses.
- Icache_valid_out  out  3  per-slot hit.
- proc2Imem_command  out  2  BUS_NONE or BUS_LOAD.
- proc2Imem_addr  out  `XLEN  line-aligned miss address (addr[2:0]=0).
- Imem2proc_response  in  MEM_TAG_W  nonzero = request accepted, carries the transaction tag.
- Imem2proc_data  in  64  fill data; [31:0] = word at addr+0, [63:32] = word at addr+4.
- Imem2proc_tag  in  MEM_TAG_W  tag of returning data; 0 = none.

Behaviour:
- Lookup (combinational, 0-cycle):
  - Slot i hits when line_valid[idx_i] is set and tag_i matches.
  - Data word is selected by addr_i[2].
  - Reads are not bypassed from a fill in the same cycle; a hit appears the cycle after the fill write.
- Reset: all line_valid=0, FSM=IDLE, proc2Imem_command=BUS_NONE, proc2Imem_addr=0, all Icache_valid_out=0, Icache_data_out=0. The memory tag register clears.
- Miss candidate: the first missing slot in order 2, 1, 0. None if all three hit.
- FSM IDLE:
  - With a candidate, hit_but_stall=0 and take_branch=0: drive BUS_LOAD with the candidate line address in the same cycle.
  - If Imem2proc_response!=0 that cycle: latch the response tag and line address, go to WAIT.
  - If the response is 0: stay in IDLE and re-evaluate next cycle. The request address may change.
- FSM WAIT:
  - Command stays BUS_NONE.
  - When Imem2proc_tag equals the latched nonzero tag: write data, tag and valid into the latched index, then go to IDLE.
  - The next request can issue the cycle after the fill (never the same cycle).
- take_branch in WAIT does not cancel the transaction. The fill completes and is installed.
- Fill to an index already holding another tag overwrites it (eviction, no writeback).
- Two or three slots mapping to the same line share one miss. The fill serves all of them.
- A response tag of 0 in WAIT, or a mismatching tag, is ignored.
- Reset mid-WAIT: the FSM returns to IDLE and a later matching tag is ignored. The latched tag clears to 0, and 0 is never matched.
- Address wrap: index and tag are taken purely by bit slicing; PCs near 2^XLEN need no special case.

Optional Feature:
- Macro: ICACHE_PREFETCH_EN.
- Enabled:
  - After a demand fill, if line L+1 (L = filled line address; L+1 = next 8-byte line of slot (2-shift) at fill time) is not resident, the FSM enters PREFETCH.
  - PREFETCH issues BUS_LOAD for L+1 using the same handshake and WAIT/fill path.
  - A demand miss present in the same cycle takes priority and drops the prefetch.
- Disabled: no PREFETCH state; shift is unused.

Test Plan:
- Reset, PCs 0/4/8 -> Icache_valid_out=000. BUS_LOAD addr 0x0 the first cycle after reset. Response=3 -> WAIT. Tag=3 with data {0x00200093,0x00100093} -> next cycle valid[2]=1, valid[1]=1, data[2]=0x00100093, valid[0]=0; then BUS_LOAD 0x8.
- Response 0 for 4 cycles -> BUS_LOAD held with addr 0x0 each cycle; no state change.
- In WAIT, Imem2proc_tag=5 (latched 3) -> no fill, valid stays 0; then tag=3 -> fill.
- Two PCs 0x0 and 0x100 (same index, CACHE_LINES=32) -> second fill evicts the first; lookup of 0x0 misses afterwards.
- hit_but_stall=1 with slot 0 missing -> proc2Imem_command=BUS_NONE until it drops.
- Reset asserted in WAIT, then tag=3 returns -> line_valid unchanged (0); FSM IDLE reissues BUS_LOAD.

Source files
------------

// File: rtl/icache_frontend.sv
// icache_frontend: 3-wide direct-mapped instruction cache with one outstanding BUS_LOAD line miss.
// Optional macro ICACHE_PREFETCH_EN adds a next-line prefetch after each demand fill.
`ifndef XLEN
`define XLEN 32
`endif

module icache_frontend #(
  parameter int unsigned CACHE_LINES = 32,
  parameter int unsigned MEM_TAG_W   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][`XLEN-1:0]      proc2Icache_addr,
  input  logic [1:0]                 shift,
  input  logic                       hit_but_stall,
  input  logic                       take_branch,
  output logic [2:0][31:0]           Icache_data_out,
  output logic [2:0]                 Icache_valid_out,
  output logic [1:0]                 proc2Imem_command,
  output logic [`XLEN-1:0]           proc2Imem_addr,
  input  logic [MEM_TAG_W-1:0]       Imem2proc_response,
  input  logic [63:0]                Imem2proc_data,
  input  logic [MEM_TAG_W-1:0]       Imem2proc_tag
);

  localparam int unsigned XLEN   = `XLEN;
  localparam int unsigned IDX_W  = $clog2(CACHE_LINES);
  localparam int unsigned LINE_W = XLEN - 3;
  localparam int unsigned TAG_W  = LINE_W - IDX_W;
  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;

`ifdef ICACHE_PREFETCH_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PREFETCH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

  logic [CACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]       line_tag  [CACHE_LINES];
  logic [63:0]            line_data [CACHE_LINES];

  state_t               state, state_n;
  logic [MEM_TAG_W-1:0] mem_tag, mem_tag_n;
  logic [LINE_W-1:0]    miss_line, miss_line_n;

  logic [2:0][IDX_W-1:0] slot_idx;
  logic [2:0][TAG_W-1:0] slot_tag;
  logic [2:0][31:0]      slot_word;
  logic [2:0]            slot_hit;
  logic                  cand_valid;
  logic [LINE_W-1:0]     cand_line;
  logic [1:0]            cmd_c;
  logic [LINE_W-1:0]     req_line_c;
  logic                  fill_c;

  // Address bits below the word offset never select anything.
  logic unused_bits;
`ifdef ICACHE_PREFETCH_EN
  assign unused_bits = ^{proc2Icache_addr[2][1:0], proc2Icache_addr[1][1:0], proc2Icache_addr[0][1:0]};
`else
  assign unused_bits = ^{proc2Icache_addr[2][1:0], proc2Icache_addr[1][1:0], proc2Icache_addr[0][1:0], shift};
`endif

  // Per-slot lookup and miss candidate; the last assignment wins, so slot 2 has priority.
  always_comb begin
    cand_valid = 1'b0;
    cand_line  = '0;
    for (int i = 0; i < 3; i++) begin
      slot_idx[i]  = proc2Icache_addr[i][3 +: IDX_W];
      slot_tag[i]  = proc2Icache_addr[i][3 + IDX_W +: TAG_W];
      slot_hit[i]  = line_valid[slot_idx[i]] && (line_tag[slot_idx[i]] == slot_tag[i]);
      slot_word[i] = proc2Icache_addr[i][2] ? line_data[slot_idx[i]][63:32]
                                            : line_data[slot_idx[i]][31:0];
      if (!slot_hit[i]) begin
        cand_valid = 1'b1;
        cand_line  = proc2Icache_addr[i][XLEN-1:3];
      end
    end
  end

  always_comb begin
    Icache_valid_out = reset ? 3'b000 : slot_hit;
    for (int i = 0; i < 3; i++)
      Icache_data_out[i] = (slot_hit[i] && !reset) ? slot_word[i] : 32'd0;
    proc2Imem_command = reset ? BUS_NONE : cmd_c;
    proc2Imem_addr    = reset ? '0 : {req_line_c, 3'b000};
  end

`ifdef ICACHE_PREFETCH_EN
  logic              pf_inflight, pf_inflight_n;
  logic [LINE_W-1:0] pf_line, pf_line_n;
  logic [1:0]        pf_slot;
  logic [LINE_W-1:0] pf_cand;
  logic              pf_resident;

  // Next line after the oldest unconsumed slot; the line being filled counts as resident.
  always_comb begin
    pf_slot     = (shift > 2'd2) ? 2'd0 : 2'(2'd2 - shift);
    pf_cand     = LINE_W'(proc2Icache_addr[pf_slot][XLEN-1:3] + LINE_W'(1));
    pf_resident = (line_valid[pf_cand[IDX_W-1:0]] &&
                   (line_tag[pf_cand[IDX_W-1:0]] == pf_cand[IDX_W +: TAG_W])) ||
                  (pf_cand == miss_line);
  end
`endif

  // Miss FSM: next state and memory command.
  always_comb begin
    state_n     = state;
    mem_tag_n   = mem_tag;
    miss_line_n = miss_line;
    cmd_c       = BUS_NONE;
    req_line_c  = '0;
    fill_c      = 1'b0;
`ifdef ICACHE_PREFETCH_EN
    pf_inflight_n = pf_inflight;
    pf_line_n     = pf_line;
`endif
    case (state)
      S_IDLE: begin
        if (cand_valid && !hit_but_stall && !take_branch) begin
          cmd_c      = BUS_LOAD;
          req_line_c = cand_line;
        end
      end
      S_WAIT: begin
        if ((mem_tag != '0) && (Imem2proc_tag == mem_tag)) begin
          fill_c    = 1'b1;
          mem_tag_n = '0;
          state_n   = S_IDLE;
`ifdef ICACHE_PREFETCH_EN
          if (!pf_inflight && !pf_resident) begin
            state_n   = S_PREFETCH;
            pf_line_n = pf_cand;
          end
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      S_PREFETCH: begin
        if (cand_valid) begin
          state_n = S_IDLE;
          if (!hit_but_stall && !take_branch) begin
            cmd_c      = BUS_LOAD;
            req_line_c = cand_line;
          end
        end else begin
          cmd_c      = BUS_LOAD;
          req_line_c = pf_line;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if ((cmd_c == BUS_LOAD) && (Imem2proc_response != '0)) begin
      mem_tag_n   = Imem2proc_response;
      miss_line_n = req_line_c;
      state_n     = S_WAIT;
`ifdef ICACHE_PREFETCH_EN
      pf_inflight_n = (state == S_PREFETCH);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_tag    <= '0;
      miss_line  <= '0;
      line_valid <= '0;
`ifdef ICACHE_PREFETCH_EN
      pf_inflight <= 1'b0;
      pf_line     <= '0;
`endif
    end else begin
      state     <= state_n;
      mem_tag   <= mem_tag_n;
      miss_line <= miss_line_n;
      if (fill_c) line_valid[miss_line[IDX_W-1:0]] <= 1'b1;
`ifdef ICACHE_PREFETCH_EN
      pf_inflight <= pf_inflight_n;
      pf_line     <= pf_line_n;
`endif
    end
  end

  // Tag/data arrays need no reset; line_valid guards them.
  always_ff @(posedge clock) begin
    if (fill_c && !reset) begin
      line_tag[miss_line[IDX_W-1:0]]  <= miss_line[IDX_W +: TAG_W];
      line_data[miss_line[IDX_W-1:0]] <= Imem2proc_data;
    end
  end

endmodule

// File: tb/tb_icache_frontend.sv
// tb_icache_frontend: table-driven scoreboard bench for icache_frontend (default build, no prefetch).
module tb_icache_frontend;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [63:0] D0   = 64'h00200093_00100093;
  localparam logic [63:0] D8   = 64'h00400093_00300093;
  localparam logic [63:0] D10  = 64'h00600093_00500093;
  localparam logic [63:0] D100 = 64'hDEAD0001_DEAD0000;
  localparam logic [63:0] DW   = 64'h11112222_33334444;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0][31:0] pcs;
  logic [1:0]      shift;
  logic            hit_but_stall, take_branch;
  logic [2:0][31:0] data_out;
  logic [2:0]      valid_out;
  logic [1:0]      cmd;
  logic [31:0]     maddr;
  logic [3:0]      resp, mtag;
  logic [63:0]     mdata;

  icache_frontend dut (
    .clock(clock), .reset(reset), .proc2Icache_addr(pcs), .shift(shift),
    .hit_but_stall(hit_but_stall), .take_branch(take_branch),
    .Icache_data_out(data_out), .Icache_valid_out(valid_out),
    .proc2Imem_command(cmd), .proc2Imem_addr(maddr),
    .Imem2proc_response(resp), .Imem2proc_data(mdata), .Imem2proc_tag(mtag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [31:0] a2, a1, a0;
    logic        hbs, tbr;
    logic [3:0]  resp, tag;
    logic [63:0] data;
    logic [2:0]  ev;
    logic [1:0]  ecmd;
    logic [31:0] eaddr, ed2, ed1, ed0;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic rst, input logic [31:0] a2, a1, a0,
                              input logic hbs, tbr, input logic [3:0] rs, tg,
                              input logic [63:0] dt, input logic [2:0] ev,
                              input logic [1:0] ecmd, input logic [31:0] eaddr, ed2, ed1, ed0);
    vec_t v;
    v.rst = rst; v.a2 = a2; v.a1 = a1; v.a0 = a0; v.hbs = hbs; v.tbr = tbr;
    v.resp = rs; v.tag = tg; v.data = dt; v.ev = ev; v.ecmd = ecmd;
    v.eaddr = eaddr; v.ed2 = ed2; v.ed1 = ed1; v.ed0 = ed0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; pcs[2] = v.a2; pcs[1] = v.a1; pcs[0] = v.a0;
    hit_but_stall = v.hbs; take_branch = v.tbr;
    resp = v.resp; mtag = v.tag; mdata = v.data;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   n;
    reset = 1'b1; pcs = '0; shift = 2'd0; hit_but_stall = 1'b0; take_branch = 1'b0;
    resp = '0; mtag = '0; mdata = '0;

    // Basic miss/fill on PCs 0/4/8, held zero responses, wrong tags
    vecs.push_back(mk(1, 32'h0, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b000, BUS_LOAD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 3, 0, 0, 3'b000, BUS_LOAD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 5, D0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 0, D0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 3, D0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b110, BUS_LOAD, 32'h8, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 7, 0, 0, 3'b110, BUS_LOAD, 32'h8, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 7, D8, 3'b110, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b111, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 32'h00300093));
    // hit_but_stall and take_branch block issue; take_branch in WAIT does not cancel
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 1, 0, 0, 0, 0, 3'b110, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 1, 0, 0, 0, 0, 3'b110, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 0, 1, 0, 0, 0, 3'b110, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 0, 0, 0, 0, 0, 3'b110, BUS_LOAD, 32'h10, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 0, 0, 2, 0, 0, 3'b110, BUS_LOAD, 32'h10, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 0, 1, 0, 2, D10, 3'b110, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 0));
    vecs.push_back(mk(0, 32'h0, 32'h4, 32'h10, 0, 0, 0, 0, 0, 3'b111, BUS_NONE, 32'h0, 32'h00100093, 32'h00200093, 32'h00500093));
    // Eviction: 0x100 shares index 0 with 0x0
    vecs.push_back(mk(0, 32'h100, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b011, BUS_LOAD, 32'h100, 0, 32'h00200093, 32'h00300093));
    vecs.push_back(mk(0, 32'h100, 32'h4, 32'h8, 0, 0, 4, 0, 0, 3'b011, BUS_LOAD, 32'h100, 0, 32'h00200093, 32'h00300093));
    vecs.push_back(mk(0, 32'h100, 32'h4, 32'h8, 0, 0, 0, 4, D100, 3'b011, BUS_NONE, 32'h0, 0, 32'h00200093, 32'h00300093));
    vecs.push_back(mk(0, 32'h100, 32'h4, 32'h8, 0, 0, 0, 0, 0, 3'b101, BUS_LOAD, 32'h0, 32'hDEAD0000, 0, 32'h00300093));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 0, 0, 3'b011, BUS_LOAD, 32'h0, 0, 32'hDEAD0001, 32'h00300093));
    // Reset mid-WAIT: stale tag 3 must not fill
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 3, 0, 0, 3'b011, BUS_LOAD, 32'h0, 0, 32'hDEAD0001, 32'h00300093));
    vecs.push_back(mk(1, 32'h0, 32'h104, 32'h8, 0, 0, 0, 0, 0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 3, D0, 3'b000, BUS_LOAD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 3, D0, 3'b000, BUS_LOAD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 6, 0, 0, 3'b000, BUS_LOAD, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 3, D0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 6, D0, 3'b000, BUS_NONE, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 32'h104, 32'h8, 0, 0, 0, 0, 0, 3'b100, BUS_LOAD, 32'h100, 32'h00100093, 0, 0));

    foreach (vecs[k]) begin
      @(posedge clock); #1;
      drive(vecs[k]);
      expq.push_back(vecs[k]);
      @(negedge clock);
      e = expq.pop_front();
      chk($sformatf("v%0d_valid", k), 64'(valid_out), 64'(e.ev));
      chk($sformatf("v%0d_cmd", k), 64'(cmd), 64'(e.ecmd));
      chk($sformatf("v%0d_addr", k), 64'(maddr), 64'(e.eaddr));
      chk($sformatf("v%0d_data2", k), 64'(data_out[2]), 64'(e.ed2));
      chk($sformatf("v%0d_data1", k), 64'(data_out[1]), 64'(e.ed1));
      chk($sformatf("v%0d_data0", k), 64'(data_out[0]), 64'(e.ed0));
    end

    // Address wrap: top-of-memory line, both words served by one fill
    @(posedge clock); #1;
    pcs[2] = 32'hFFFF_FFF8; pcs[1] = 32'hFFFF_FFFC; pcs[0] = 32'h0;
    resp = '0; mtag = '0; mdata = '0;
    n = 0;
    @(negedge clock);
    while (cmd !== BUS_LOAD && n < 8) begin @(negedge clock); n++; end
    chk("wrap_load_seen", 64'(cmd), 64'(BUS_LOAD));
    chk("wrap_addr", 64'(maddr), 64'h0000_0000_FFFF_FFF8);
    @(posedge clock); #1 resp = 4'd9;
    @(posedge clock); #1 resp = '0; mtag = 4'd9; mdata = DW;
    @(posedge clock); #1 mtag = '0; mdata = '0;
    n = 0;
    @(negedge clock);
    while (valid_out[2] !== 1'b1 && n < 5) begin @(negedge clock); n++; end
    chk("wrap_valid", 64'(valid_out), 64'(3'b111));
    chk("wrap_data2", 64'(data_out[2]), 64'h3333_4444);
    chk("wrap_data1", 64'(data_out[1]), 64'h1111_2222);
    chk("wrap_data0", 64'(data_out[0]), 64'h0010_0093);
    chk("wrap_cmd_idle", 64'(cmd), 64'(BUS_NONE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
